// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = 16;

    // All rows released (active-low drive, nothing selected).
    localparam logic [3:0] ROW_IDLE = 4'b1111;

    typedef enum logic [2:0] {
        DRIVE   = 3'd0,
        SETTLE  = 3'd1,
        SAMPLE  = 3'd2,
        COMPARE = 3'd3,
        EMIT    = 3'd4
    } scan_state_e;

    // Key index of a matrix position: row*NUM_COLS + col.
    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        return 4'(int'(row) * NUM_COLS + int'(col));
    endfunction

    // Active-low drive pattern selecting a single row.
    function automatic logic [3:0] row_select_n(input logic [1:0] row);
        return ~(4'b0001 << row);
    endfunction

endpackage

// File: rtl/keypad_scanner_col_sync.sv
// Two-flop synchronizer for the asynchronous column sense lines.
// Resets to all-ones, which reads as "no column pulled low".
module col_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    // Next values of the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, released to idle (all-ones) on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {WIDTH{1'b1}};
            sync_q <= {WIDTH{1'b1}};
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: drives one row at a time, samples the
// synchronized columns, debounces each key across full scans and reports
// press/release events one per cycle in ascending key order.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int STABLE_SCANS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  row_n,
    input  logic [3:0]  col_n,
    output logic [15:0] keys,
    output logic        key_event,
    output logic [3:0]  key_code,
    output logic        key_down,
    output logic        scan_done
);

    if (SETTLE_CYCLES < 4) begin : g_bad_settle
        $error("keypad_scanner: SETTLE_CYCLES must be >= 4 to absorb column synchronizer latency");
    end
    if ((STABLE_SCANS < 1) || (STABLE_SCANS > 15)) begin : g_bad_stable
        $error("keypad_scanner: STABLE_SCANS must be in 1..15");
    end

    localparam int                   SETTLE_W    = $clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [3:0]           STABLE_LAST = 4'(STABLE_SCANS - 1);
    localparam logic [1:0]           LAST_ROW    = 2'(NUM_ROWS - 1);

    scan_state_e           state_d, state_q;
    logic [1:0]            row_d, row_q;
    logic [SETTLE_W-1:0]   settle_d, settle_q;
    logic [3:0]            emit_d, emit_q;
    logic [NUM_KEYS-1:0]   raw_d, raw_q;
    logic [NUM_KEYS-1:0]   keys_d, keys_q;
    logic [NUM_KEYS-1:0]   changed_d, changed_q;
    logic [3:0]            cnt_d [NUM_KEYS];
    logic [3:0]            cnt_q [NUM_KEYS];
    logic [3:0]            row_n_d, row_n_q;
    logic                  key_event_d, key_event_q;
    logic [3:0]            key_code_d, key_code_q;
    logic                  key_down_d, key_down_q;
    logic                  scan_done_d, scan_done_q;
    logic [3:0]            col_sync_s;

    col_sync #(
        .WIDTH(NUM_COLS)
    ) u_col_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (col_n),
        .q    (col_sync_s)
    );

    // Scan sequencing, debounce and event emission (next-state logic).
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        settle_d    = settle_q;
        emit_d      = emit_q;
        raw_d       = raw_q;
        keys_d      = keys_q;
        changed_d   = changed_q;
        cnt_d       = cnt_q;
        row_n_d     = row_n_q;
        key_event_d = 1'b0;
        key_code_d  = key_code_q;
        key_down_d  = key_down_q;
        scan_done_d = 1'b0;

        case (state_q)
            DRIVE: begin
                row_n_d  = row_select_n(row_q);
                settle_d = '0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            SAMPLE: begin
                // Columns read active-high into the raw key image.
                raw_d[key_index(row_q, 2'd0) +: 4] = ~col_sync_s;
                if (row_q == LAST_ROW) begin
                    row_d   = 2'd0;
                    row_n_d = ROW_IDLE;
                    state_d = COMPARE;
                end else begin
                    row_d   = row_q + 2'd1;
                    state_d = DRIVE;
                end
            end
            COMPARE: begin
                // A key flips only after disagreeing for STABLE_SCANS scans in a row.
                for (int i = 0; i < NUM_KEYS; i++) begin
                    if (raw_q[i] == keys_q[i]) begin
                        cnt_d[i] = 4'd0;
                    end else if (cnt_q[i] == STABLE_LAST) begin
                        keys_d[i]    = raw_q[i];
                        cnt_d[i]     = 4'd0;
                        changed_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end
                row_n_d = ROW_IDLE;
                emit_d  = 4'd0;
                state_d = EMIT;
            end
            EMIT: begin
                row_n_d = ROW_IDLE;
                if (changed_q[emit_q]) begin
                    key_event_d        = 1'b1;
                    key_code_d         = emit_q;
                    key_down_d         = keys_q[emit_q];
                    changed_d[emit_q]  = 1'b0;
                end else begin
                    key_event_d = 1'b0;
                end
                if (emit_q == 4'd15) begin
                    scan_done_d = 1'b1;
                    emit_d      = 4'd0;
                    state_d     = DRIVE;
                end else begin
                    emit_d = emit_q + 4'd1;
                end
            end
            default: begin
                row_n_d = ROW_IDLE;
                row_d   = 2'd0;
                state_d = DRIVE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DRIVE;
            row_q       <= 2'd0;
            settle_q    <= '0;
            emit_q      <= 4'd0;
            raw_q       <= 16'h0000;
            keys_q      <= 16'h0000;
            changed_q   <= 16'h0000;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= 4'd0;
            end
            row_n_q     <= ROW_IDLE;
            key_event_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_down_q  <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            settle_q    <= settle_d;
            emit_q      <= emit_d;
            raw_q       <= raw_d;
            keys_q      <= keys_d;
            changed_q   <= changed_d;
            cnt_q       <= cnt_d;
            row_n_q     <= row_n_d;
            key_event_q <= key_event_d;
            key_code_q  <= key_code_d;
            key_down_q  <= key_down_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign row_n     = row_n_q;
    assign keys      = keys_q;
    assign key_event = key_event_q;
    assign key_code  = key_code_q;
    assign key_down  = key_down_q;
    assign scan_done = scan_done_q;

endmodule
